// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the round-robin burst arbiter
package arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority pick: first requester at or after ptr, circularly
module rr_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               found,
  output logic [1:0]         idx
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [1:0]           rot_idx;

  // Doubling the vector turns the rotation into a plain right shift.
  assign req_dbl = {req, req};
  assign req_rot = NUM_REQ'(req_dbl >> ptr);

  always_comb begin
    rot_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) rot_idx = 2'(i);
    end
  end

  assign found = |req;
  assign idx   = rot_idx + ptr;

endmodule

// File: rtl/rr_burst_arbiter.sv
// rtl/rr_burst_arbiter.sv - 4-way round-robin arbiter with burst ownership and one-cycle turnaround
module rr_burst_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_BURST = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] last,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [1:0]         owner,
  output logic [1:0]         ptr,
  output logic [3:0]         beat_cnt
);

  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         owner_q, owner_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               pick_found;
  logic [1:0]         pick_idx;
  logic               release_burst;

  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Only the owner's request and last bits matter; the cap preempts regardless.
  assign release_burst = ~req[owner_q] | last[owner_q] | (cnt_q == BURST_LAST);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, TURN: begin
        if (en && pick_found) begin
          state_d = OWN;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          owner_d = pick_idx;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      OWN: begin
        if (release_burst) begin
          state_d = TURN;
          gnt_d   = '0;
          ptr_d   = owner_q + 2'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = |gnt_q;
  assign owner     = owner_q;
  assign ptr       = ptr_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// tb/tb_rr_burst_arbiter.sv - directed vector bench for rr_burst_arbiter
module tb_rr_burst_arbiter;

  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       en;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic [1:0] ptr;
    logic [3:0] cnt;
  } vec_t;

  logic       clock;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] last;
  logic       en;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] owner;
  logic [1:0] ptr;
  logic [3:0] beat_cnt;

  int   checks;
  int   errors;
  vec_t vecs[$];

  rr_burst_arbiter #(.MAX_BURST(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (req),
    .last      (last),
    .en        (en),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .owner     (owner),
    .ptr       (ptr),
    .beat_cnt  (beat_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b, expected %b", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [3:0] e_gnt, input logic [1:0] e_owner,
                         input logic [1:0] e_ptr, input logic [3:0] e_cnt);
    chk("gnt", idx, gnt, e_gnt);
    chk("gnt_valid", idx, {3'b0, gnt_valid}, {3'b0, |e_gnt});
    chk("owner", idx, {2'b0, owner}, {2'b0, e_owner});
    chk("ptr", idx, {2'b0, ptr}, {2'b0, e_ptr});
    chk("beat_cnt", idx, beat_cnt, e_cnt);
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] l, input logic e,
                     input logic [3:0] g, input logic [1:0] o, input logic [1:0] p, input logic [3:0] c);
    vec_t v;
    v.req = r; v.last = l; v.en = e; v.gnt = g; v.owner = o; v.ptr = p; v.cnt = c;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic e);
    @(negedge clock);
    req = r; last = l; en = e;
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    req     = 4'b0;
    last    = 4'b0;
    en      = 1'b0;
    reset_n = 1'b0;

    // Single requester, last on 4th beat, then re-grant after TURN.
    add(4'b0001, 4'b0000, 1, 4'b0001, 0, 0, 0);
    add(4'b0001, 4'b0000, 1, 4'b0001, 0, 0, 1);
    add(4'b0001, 4'b0000, 1, 4'b0001, 0, 0, 2);
    add(4'b0001, 4'b0000, 1, 4'b0001, 0, 0, 3);
    add(4'b0001, 4'b0001, 1, 4'b0000, 0, 1, 0);
    add(4'b0001, 4'b0000, 1, 4'b0001, 0, 1, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 0, 1, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 0, 1, 0);
    // Round-robin with all requesting; non-owner last bits are ignored.
    add(4'b1111, 4'b0000, 1, 4'b0010, 1, 1, 0);
    add(4'b1111, 4'b1101, 1, 4'b0010, 1, 1, 1);
    add(4'b1111, 4'b1111, 1, 4'b0000, 1, 2, 0);
    add(4'b1111, 4'b0000, 1, 4'b0100, 2, 2, 0);
    add(4'b1111, 4'b0000, 1, 4'b0100, 2, 2, 1);
    add(4'b1111, 4'b1111, 1, 4'b0000, 2, 3, 0);
    add(4'b1111, 4'b0000, 1, 4'b1000, 3, 3, 0);
    add(4'b1111, 4'b0000, 1, 4'b1000, 3, 3, 1);
    add(4'b1111, 4'b1111, 1, 4'b0000, 3, 0, 0);
    add(4'b1111, 4'b0000, 1, 4'b0001, 0, 0, 0);
    add(4'b1111, 4'b0000, 1, 4'b0001, 0, 0, 1);
    add(4'b1111, 4'b1111, 1, 4'b0000, 0, 1, 0);
    // Owner 1 withdraws; ptr=2 so 3 wins over 0.
    add(4'b1011, 4'b0000, 1, 4'b0010, 1, 1, 0);
    add(4'b1011, 4'b0000, 1, 4'b0010, 1, 1, 1);
    add(4'b1001, 4'b0000, 1, 4'b0000, 1, 2, 0);
    add(4'b1001, 4'b0000, 1, 4'b1000, 3, 2, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 3, 0, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 3, 0, 0);
    // Enable gating.
    add(4'b0011, 4'b0000, 0, 4'b0000, 3, 0, 0);
    add(4'b0011, 4'b0000, 0, 4'b0000, 3, 0, 0);
    add(4'b0011, 4'b0000, 1, 4'b0001, 0, 0, 0);
    add(4'b0011, 4'b0000, 0, 4'b0001, 0, 0, 1);
    add(4'b0011, 4'b0001, 0, 4'b0000, 0, 1, 0);
    add(4'b0011, 4'b0000, 0, 4'b0000, 0, 1, 0);
    add(4'b0011, 4'b0000, 0, 4'b0000, 0, 1, 0);
    add(4'b0011, 4'b0000, 1, 4'b0010, 1, 1, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 1, 2, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 1, 2, 0);
    // Burst cap: 8 granted cycles, cap coincides with last, capped owner loses priority.
    for (int b = 0; b < 8; b++) add(4'b0100, 4'b0000, 1, 4'b0100, 2, 2, 4'(b));
    add(4'b0100, 4'b0100, 1, 4'b0000, 2, 3, 0);
    add(4'b0101, 4'b0000, 1, 4'b0001, 0, 3, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 0, 1, 0);
    add(4'b0000, 4'b0000, 1, 4'b0000, 0, 1, 0);

    repeat (2) @(posedge clock);
    #1;
    chk_all(-1, 4'b0000, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].req, vecs[i].last, vecs[i].en);
      chk_all(i, vecs[i].gnt, vecs[i].owner, vecs[i].ptr, vecs[i].cnt);
    end

    // Reset mid-burst with owner 2: outputs clear without waiting for an edge.
    step(4'b0100, 4'b0000, 1);
    chk_all(100, 4'b0100, 2, 1, 0);
    step(4'b0100, 4'b0000, 1);
    step(4'b0100, 4'b0000, 1);
    chk_all(101, 4'b0100, 2, 1, 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all(102, 4'b0000, 0, 0, 0);
    step(4'b0000, 4'b0000, 1);
    @(negedge clock);
    reset_n = 1'b1;
    step(4'b0000, 4'b0000, 1);
    chk_all(103, 4'b0000, 0, 0, 0);
    step(4'b0110, 4'b0000, 1);
    chk_all(104, 4'b0010, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Registered 4-requester round-robin arbiter that shares one downstream resource (bus/port) between four clients with burst ownership. A grant is held for a whole burst: until the owner drops its request, signals its last beat, or reaches a burst-length cap. Fairness comes from a rotating priority pointer, and a mandatory one-cycle turnaround separates owners. It sits between the requesting units and the shared resource, using the same rotating-priority pick as the existing selector tree.

## Interface
Parameters:
- MAX_BURST, default 8: maximum beats per grant (legal range 2..16).

Ports:
- clock, input, 1: single clock; all state updates on posedge.
- reset_n, input, 1: asynchronous, active-low reset.
- req, input, 4: per-requester request, level-sensitive.
- last, input, 4: per-requester final-beat flag; only the owner's bit is used.
- en, input, 1: arbitration enable; gates new grants only.
- gnt, output, 4: one-hot grant, or all zero; registered.
- gnt_valid, output, 1: |gnt; registered.
- owner, output, 2: index of the current/most recent owner.
- ptr, output, 2: highest-priority requester index for the next arbitration.
- beat_cnt, output, 4: beats completed in the current grant.

## Operation
- States: IDLE, OWN, TURN.
- Pick function: the first i in the circular order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with req[i]=1.
- IDLE, TURN:
  - If en && |req: next edge gnt <= onehot(pick), owner <= pick, beat_cnt <= 0, state <= OWN.
  - Otherwise state <= IDLE and gnt stays 0.
- OWN: every cycle in OWN is one beat.
  - release = ~req[owner] | last[owner] | (beat_cnt == MAX_BURST-1).
  - If release: next edge gnt <= 0, ptr <= owner+1 (mod 4), beat_cnt <= 0, state <= TURN.
  - Else: beat_cnt <= beat_cnt+1.
- No preemption other than the MAX_BURST cap. en=0 never revokes an active grant.
- req from non-owners during OWN is ignored until TURN.
- ptr changes only on release; a capped owner drops to lowest priority.
- owner holds its value after release (last owner) until the next grant.

## Timing
- Reset (asynchronous, immediate): gnt=0, gnt_valid=0, owner=0, ptr=0, beat_cnt=0, state=IDLE.
- Grant latency: req sampled at edge k in IDLE/TURN gives gnt high from edge k onward (visible the cycle after the request is first presented). No combinational req-to-gnt path.
- Release latency: the release condition true in cycle c means gnt is low after edge c. Cycle c itself is still a granted beat.
- Minimum gap between owners: exactly one cycle (TURN) with gnt=0.
- Maximum continuous grant: MAX_BURST cycles.
- Simultaneous events:
  - last and ~req in the same cycle: a single release.
  - Cap and last in the same cycle: a single release; ptr advances once.
- Wrap-around: ptr and owner+1 wrap 3 -> 0.
- Starvation bound: a requester holding req is granted within 3*(MAX_BURST+1)+1 cycles while en=1.
- reset_n asserted mid-burst: gnt drops asynchronously; state is re-entered as after power-up.

## Structure
- Package arb_pkg: state enum (IDLE, OWN, TURN) and NUM_REQ=4.
- Sub-module rr_pick: combinational. Inputs req[3:0] and ptr[1:0]; outputs found and idx[1:0]. Implemented by rotating req by ptr, doing a fixed-priority pick, then rotating back.
- The top level holds the FSM, pointer, owner and beat counter.

## Test plan
- Reset mid-burst: owner=2 at beat 3, pulse reset_n low -> gnt=0 immediately; owner=0, ptr=0, beat_cnt=0; state IDLE after release.
- Single requester: req=0001, last[0] at the 4th beat -> gnt=0001 for exactly 4 cycles, 1 TURN cycle, then ptr=1. Re-grant of client 0 follows after TURN if req is still high.
- Round-robin: req=1111 held, each client asserts last on its 2nd beat -> grant order 0,1,2,3,0. Each grant is 2 cycles with a 1-cycle gap; ptr sequence 1,2,3,0.
- Burst cap: MAX_BURST=8, req=0100 held, last never asserted -> gnt=0100 for exactly 8 cycles. beat_cnt reaches 7, then forced release with ptr=3.
- Enable gating: en=0 with req=0011 -> no grant ever. en dropped during OWN -> grant continues to its natural release, then no new grant until en=1.
- Request withdrawal plus priority: owner=1 drops req while req[3] and req[0] are high -> gnt low one cycle, then gnt=1000 (ptr=2, so 3 precedes 0).
